// File: rtl/timer.sv
// Game Boy timer (DIV/TIMA/TMA/TAC) and interrupt flag/enable registers on the CPU bus.
// Define TIMER_RELOAD_DELAY_EN to hold TIMA at 00 for one cycle before the TMA reload.
module timer (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] addr,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic [4:0]  irqin,
    input  logic        ack,
    input  logic [2:0]  ackidx,
    output logic [4:0]  irq
);

    localparam logic [15:0] ADDR_DIV  = 16'hff04;
    localparam logic [15:0] ADDR_TIMA = 16'hff05;
    localparam logic [15:0] ADDR_TMA  = 16'hff06;
    localparam logic [15:0] ADDR_TAC  = 16'hff07;
    localparam logic [15:0] ADDR_IF   = 16'hff0f;
    localparam logic [15:0] ADDR_IE   = 16'hffff;

    logic [15:0] div_q, div_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [7:0]  out_q, out_d;
    logic        tin_q, tin_d;
`ifdef TIMER_RELOAD_DELAY_EN
    logic        pend_q, pend_d;
`endif

    logic        tap;
    logic        timer_in;
    logic        timer_fall;
    logic        reload;
    logic        wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;
    logic [7:0]  rd_data;

    assign wr_div  = store && (addr == ADDR_DIV);
    assign wr_tima = store && (addr == ADDR_TIMA);
    assign wr_tma  = store && (addr == ADDR_TMA);
    assign wr_tac  = store && (addr == ADDR_TAC);
    assign wr_if   = store && (addr == ADDR_IF);
    assign wr_ie   = store && (addr == ADDR_IE);

    always_comb begin
        unique case (tac_q[1:0])
            2'b00:   tap = div_q[9];
            2'b01:   tap = div_q[3];
            2'b10:   tap = div_q[5];
            default: tap = div_q[7];
        endcase
    end

    // Gating the tap before edge detection is what makes DIV writes and
    // timer disables produce a spurious increment when the tap is high.
    assign timer_in   = tap & tac_q[2];
    assign timer_fall = tin_q & ~timer_in;

    always_comb begin
        unique case (addr)
            ADDR_DIV:  rd_data = div_q[15:8];
            ADDR_TIMA: rd_data = tima_q;
            ADDR_TMA:  rd_data = tma_q;
            ADDR_TAC:  rd_data = {5'b11111, tac_q};
            ADDR_IF:   rd_data = {3'b111, if_q};
            ADDR_IE:   rd_data = ie_q;
            default:   rd_data = 8'hff;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        div_d  = wr_div ? 16'h0000 : div_q + 16'd1;
        tma_d  = wr_tma ? indata : tma_q;
        tac_d  = wr_tac ? indata[2:0] : tac_q;
        ie_d   = wr_ie ? indata : ie_q;
        out_d  = load ? rd_data : out_q;
        tin_d  = timer_in;
        tima_d = tima_q;
        reload = 1'b0;
`ifdef TIMER_RELOAD_DELAY_EN
        pend_d = 1'b0;
        if (pend_q) begin
            if (wr_tima) begin
                tima_d = indata;
            end else begin
                tima_d = tma_d;
                reload = 1'b1;
            end
        end else if (wr_tima) begin
            tima_d = indata;
        end else if (timer_fall) begin
            if (tima_q == 8'hff) begin
                tima_d = 8'h00;
                pend_d = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`else
        if (wr_tima) begin
            tima_d = indata;
        end else if (timer_fall) begin
            if (tima_q == 8'hff) begin
                tima_d = tma_q;
                reload = 1'b1;
            end else begin
                tima_d = tima_q + 8'd1;
            end
        end
`endif
        // Priority store < ack < set: later assignments override earlier ones.
        if_d = if_q;
        if (wr_if) begin
            if_d = indata[4:0];
        end
        if (ack && (ackidx <= 3'd4)) begin
            if_d[ackidx] = 1'b0;
        end
        if_d = if_d | irqin | {2'b00, reload, 2'b00};
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q  <= 16'h0000;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            if_q   <= 5'b00000;
            ie_q   <= 8'h00;
            out_q  <= 8'hff;
            tin_q  <= 1'b0;
`ifdef TIMER_RELOAD_DELAY_EN
            pend_q <= 1'b0;
`endif
        end else begin
            div_q  <= div_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            if_q   <= if_d;
            ie_q   <= ie_d;
            out_q  <= out_d;
            tin_q  <= tin_d;
`ifdef TIMER_RELOAD_DELAY_EN
            pend_q <= pend_d;
`endif
        end
    end

    assign outdata = out_q;
    assign irq     = if_q & ie_q[4:0];

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus random bus traffic,
// all checked against a cycle-level behavioural model of the register file.
module tb_timer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  indata = 8'h00;
    logic [7:0]  outdata;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [4:0]  irqin = 5'b00000;
    logic        ack = 1'b0;
    logic [2:0]  ackidx = 3'd0;
    logic [4:0]  irq;

    int n_cmp = 0;
    int n_mis = 0;

    timer dut (
        .clock   (clock),
        .resetn  (resetn),
        .addr    (addr),
        .indata  (indata),
        .outdata (outdata),
        .load    (load),
        .store   (store),
        .irqin   (irqin),
        .ack     (ack),
        .ackidx  (ackidx),
        .irq     (irq)
    );

    initial forever #5 clock = ~clock;

    // Reference model state
    logic [15:0] m_div;
    logic [7:0]  m_tima, m_tma, m_ie, m_out;
    logic [2:0]  m_tac;
    logic [4:0]  m_if;
    logic        m_prev, m_pend;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_ie = 8'h0; m_out = 8'hff;
        m_tac = 3'b0; m_if = 5'b0; m_prev = 1'b0; m_pend = 1'b0;
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        case (a)
            16'hff04: return m_div[15:8];
            16'hff05: return m_tima;
            16'hff06: return m_tma;
            16'hff07: return {5'b11111, m_tac};
            16'hff0f: return {3'b111, m_if};
            16'hffff: return m_ie;
            default:  return 8'hff;
        endcase
    endfunction

    function automatic logic model_tin();
        int b;
        case (m_tac[1:0])
            2'd0:    b = 9;
            2'd1:    b = 3;
            2'd2:    b = 5;
            default: b = 7;
        endcase
        return m_div[b] & m_tac[2];
    endfunction

    function automatic logic will_reload();
`ifdef TIMER_RELOAD_DELAY_EN
        return m_pend;
`else
        return m_prev && !model_tin() && (m_tima == 8'hff);
`endif
    endfunction

    // One clock: advance the model from the current inputs, clock the DUT,
    // compare, then drop all single-cycle strobes.
    task automatic step();
        logic        tin, inc, rl, n_pend, wr_tima;
        logic [15:0] n_div;
        logic [7:0]  n_tima, n_tma, n_ie, n_out;
        logic [2:0]  n_tac;
        logic [4:0]  n_if;
        tin     = model_tin();
        inc     = m_prev && !tin;
        wr_tima = store && (addr == 16'hff05);
        n_out   = load ? m_read(addr) : m_out;
        n_div   = (store && addr == 16'hff04) ? 16'h0 : m_div + 16'd1;
        n_tma   = (store && addr == 16'hff06) ? indata : m_tma;
        n_tac   = (store && addr == 16'hff07) ? indata[2:0] : m_tac;
        n_ie    = (store && addr == 16'hffff) ? indata : m_ie;
        rl      = 1'b0;
        n_pend  = 1'b0;
        n_tima  = m_tima;
`ifdef TIMER_RELOAD_DELAY_EN
        if (m_pend) begin
            if (wr_tima) n_tima = indata;
            else begin n_tima = n_tma; rl = 1'b1; end
        end else
`endif
        if (wr_tima) n_tima = indata;
        else if (inc) begin
            if (m_tima == 8'hff) begin
`ifdef TIMER_RELOAD_DELAY_EN
                n_tima = 8'h00; n_pend = 1'b1;
`else
                n_tima = m_tma; rl = 1'b1;
`endif
            end else n_tima = m_tima + 8'd1;
        end
        n_if = m_if;
        if (store && addr == 16'hff0f) n_if = indata[4:0];
        if (ack && ackidx < 3'd5) n_if[ackidx] = 1'b0;
        n_if = n_if | irqin;
        if (rl) n_if[2] = 1'b1;

        @(posedge clock);
        #1;
        m_div = n_div; m_tima = n_tima; m_tma = n_tma; m_tac = n_tac; m_ie = n_ie;
        m_out = n_out; m_if = n_if; m_prev = tin; m_pend = n_pend;
        check("outdata", outdata, m_out);
        check("irq", {3'b000, irq}, {3'b000, m_if & m_ie[4:0]});
        load = 1'b0; store = 1'b0; ack = 1'b0; irqin = 5'b00000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a; indata = d; store = 1'b1;
        step();
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        addr = a; load = 1'b1;
        step();
        check(tag, outdata, exp);
    endtask

    initial begin
        logic        seen_ff, seen_f0, seen_00, found;
        logic [7:0]  exp_t;
        logic [15:0] addrs [8];

        model_reset();
        #22 resetn = 1'b1;
        step();

        // Build some state, then reset asynchronously mid-cycle
        wr(16'hff06, 8'h5a);
        wr(16'hffff, 8'hff);
        irqin = 5'b10011; step();
        for (int i = 0; i < 40; i++) step();
        #3 resetn = 1'b0;
        #1;
        model_reset();
        check("rst_outdata", outdata, 8'hff);
        check("rst_irq", {3'b000, irq}, 8'h00);
        #2 resetn = 1'b1;
        rd("rst_tma", 16'hff06, 8'h00);
        rd("rst_tac", 16'hff07, 8'hf8);
        rd("rst_if", 16'hff0f, 8'he0);
        rd("rst_ie", 16'hffff, 8'h00);
        for (int i = 0; i < 400 && m_div != 16'd256; i++) step();
        rd("div_at_256", 16'hff04, 8'h01);

        // Overflow and reload, tap = divcnt[3]
        wr(16'hff07, 8'h05);
        wr(16'hff06, 8'hf0);
        wr(16'hff05, 8'hfe);
        wr(16'hff0f, 8'h00);
        seen_ff = 0; seen_f0 = 0; seen_00 = 0;
        for (int i = 0; i < 80; i++) begin
            addr = 16'hff05; load = 1'b1;
            step();
            if (outdata == 8'hff) seen_ff = 1;
            if (outdata == 8'hf0) seen_f0 = 1;
            if (outdata == 8'h00) seen_00 = 1;
        end
        check("seen_ff", {7'b0, seen_ff}, 8'h01);
        check("seen_f0", {7'b0, seen_f0}, 8'h01);
`ifdef TIMER_RELOAD_DELAY_EN
        check("seen_00", {7'b0, seen_00}, 8'h01);
`else
        check("seen_00", {7'b0, seen_00}, 8'h00);
`endif
        rd("if_after_reload", 16'hff0f, 8'he4);

`ifdef TIMER_RELOAD_DELAY_EN
        // TIMA store during the pending cycle cancels the reload
        wr(16'hff05, 8'hff);
        wr(16'hff0f, 8'h00);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_pend) begin found = 1; break; end
            step();
        end
        check("pend_found", {7'b0, found}, 8'h01);
        wr(16'hff05, 8'h33);
        rd("cancel_tima", 16'hff05, 8'h33);
        rd("cancel_if", 16'hff0f, 8'he0);
`endif

        // DIV write while divcnt[9] is high gives exactly one increment
        wr(16'hff07, 8'h04);
        wr(16'hff05, 8'h10);
        found = 0;
        for (int i = 0; i < 1200; i++) begin
            if (m_div[9] && m_prev && m_div[8:0] < 9'd300) begin found = 1; break; end
            step();
        end
        check("div9_found", {7'b0, found}, 8'h01);
        exp_t = m_tima + 8'd1;
        wr(16'hff04, 8'h77);
        for (int i = 0; i < 3; i++) step();
        rd("div_cleared", 16'hff04, 8'h00);
        rd("div_write_inc", 16'hff05, exp_t);

        // Interrupt set / ack / priority
        wr(16'hff07, 8'h05);
        wr(16'hff05, 8'h00);
        wr(16'hffff, 8'h05);
        wr(16'hff0f, 8'h00);
        irqin = 5'b00001; step();
        check("irq_set", {3'b000, irq}, 8'h01);
        ack = 1'b1; ackidx = 3'd0; step();
        check("irq_ack", {3'b000, irq}, 8'h00);
        rd("if_after_ack", 16'hff0f, 8'he0);
        wr(16'hff05, 8'hff);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (will_reload()) begin
                found = 1;
                ack = 1'b1; ackidx = 3'd2;
                step();
                break;
            end
            step();
        end
        check("reload_found", {7'b0, found}, 8'h01);
        rd("set_beats_ack", 16'hff0f, 8'he4);

        // Unmapped reads and IF readback
        rd("unmapped_ff03", 16'hff03, 8'hff);
        rd("unmapped_ff10", 16'hff10, 8'hff);
        wr(16'hff0f, 8'h00);
        rd("if_cleared", 16'hff0f, 8'he0);

        // Load and store to the same address return the pre-write value
        addr = 16'hff06; indata = 8'hc3; load = 1'b1; store = 1'b1;
        exp_t = m_tma;
        step();
        check("rd_wr_same", outdata, exp_t);

        // Random bus traffic
        addrs[0] = 16'hff04; addrs[1] = 16'hff05; addrs[2] = 16'hff06; addrs[3] = 16'hff07;
        addrs[4] = 16'hff0f; addrs[5] = 16'hffff; addrs[6] = 16'hff03; addrs[7] = 16'hff10;
        for (int i = 0; i < 2500; i++) begin
            addr   = ($urandom_range(0, 15) == 0) ? 16'($urandom) : addrs[$urandom_range(0, 7)];
            indata = 8'($urandom);
            load   = ($urandom_range(0, 1) == 1);
            store  = ($urandom_range(0, 19) == 0);
            irqin  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b00000;
            ack    = ($urandom_range(0, 7) == 0);
            ackidx = 3'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

Game Boy timer and interrupt-flag block on the CPU memory bus: DIV/TIMA/TMA/TAC at FF04–FF07, IF at FF0F, IE at FFFF. Clocked by the CPU clock alongside `link`, `ram` and `mbc1`. Read data is returned through the top-level `indata` mux. Produces the pending-interrupt vector consumed by `lr35902`.

## Interface
- `ADDR_DIV`, 16'hff04: base of the DIV/TIMA/TMA/TAC window (four consecutive addresses).
- `ADDR_IF`, 16'hff0f: interrupt flag register address.
- `ADDR_IE`, 16'hffff: interrupt enable register address.
- `clock`  in  1  CPU clock (`tclock`); all state on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `addr`  in  16  bus address.
- `indata`  in  8  write data from CPU.
- `outdata`  out  8  registered read data.
- `load`  in  1  read strobe.
- `store`  in  1  write strobe.
- `irqin`  in  5  set pulses for IF bits (0 vblank, 1 stat, 2 unused here, 3 serial, 4 joypad).
- `ack`  in  1  CPU interrupt acknowledge.
- `ackidx`  in  3  IF bit cleared by `ack` (0–4; 5–7 ignored).
- `irq`  out  5  `IF & IE`, combinational from registers.

## Operation
- `divcnt[15:0]` increments every clock, wraps 16'hffff→0. DIV = `divcnt[15:8]`. Any store to DIV clears `divcnt`.
- TAC[2] enables the timer. TAC[1:0] selects the tap: 00→`divcnt[9]`, 01→`[3]`, 10→`[5]`, 11→`[7]`.
- The timer input is `tap & TAC[2]`. TIMA increments on every 1→0 transition of this signal, detected against its previous-cycle value. Consequences:
  - A DIV write while the tap is 1 causes an increment.
  - Clearing TAC[2] while the tap is 1 causes an increment.
- TIMA overflow (FF→00): see Configuration for the reload rule. When the reload happens, TIMA←TMA and IF[2]←1.
- IF[4:0]:
  - Set bit n on `irqin[n]`, or on a timer reload (bit 2).
  - Clear bit `ackidx` on `ack`.
  - A store to IF writes the bits directly.
  - Priority: store < ack < set. A set in the same cycle as an ack wins.
- IE is a full 8-bit register. Only IE[4:0] reaches `irq`.
- Read values:
  - IF reads {3'b111, IF[4:0]}.
  - TAC reads {5'b11111, TAC[2:0]}.
  - Unmapped addresses read 8'hff.
- Store to TIMA writes TIMA. A store coinciding with an increment: the store wins.

## Timing
- Reset values: `divcnt`=0, TIMA=0, TMA=0, TAC=0, IF=0, IE=0, `outdata`=8'hff, `irq`=0, edge-detect history=0, reload-pending=0.
- Writes take effect at the posedge where `store` is sampled high. The register shows the new value on the next cycle.
- Reads: `outdata` is registered at the posedge where `load` is sampled high, giving one-cycle latency. `outdata` holds that value until the next sampled load. This matches the top-level `addrlatch2` selection.
- Simultaneous load and store to the same address: `outdata` returns the pre-write value.
- `irq` follows register state with no added delay. An `irqin` pulse is visible on `irq` the cycle after it is sampled (when enabled).
- Reset asserted mid-operation forces every value listed above on the same instant, independent of `clock`.

## Configuration
- `TIMER_RELOAD_DELAY_EN` defined:
  - On overflow, TIMA reads 8'h00 for exactly one cycle (reload-pending).
  - On the following edge, TIMA←TMA and IF[2]←1.
  - A TIMA store during the pending cycle cancels the reload and the IF set.
  - A TMA store during the pending cycle supplies the new value to the reload.
- Undefined:
  - TIMA←TMA and IF[2]←1 on the same edge as the overflow, with no pending state.
  - TIMA never reads 00 due to overflow unless TMA=00.

## Test plan
- Reset with `resetn`=0 mid-count → all registers 0, `outdata`=ff, `irq`=0. After release, read FF04 at cycle 256 → 8'h01.
- TAC=3'b101, TMA=8'hf0, TIMA=8'hfe. The tap is `divcnt[3]`, so its falling edge occurs every 16 clocks. Expect:
  - TIMA = fe → ff → overflow.
  - With macro: TIMA reads 00 for one cycle, then f0, and IF reads e4.
  - Without macro: TIMA goes directly to f0 with IF = e4.
- With macro, overflow followed by a store TIMA=8'h33 in the pending cycle → TIMA=33, IF[2] stays 0.
- TAC=3'b100, run until `divcnt[9]`=1, store DIV → TIMA increments by exactly 1 and DIV reads 00.
- IE=8'h05, `irqin`=5'b00001 for one cycle → `irq`=5'b00001. `ack`=1, `ackidx`=0 → `irq`=0, IF reads e0. `ack` with `ackidx`=2 in the same cycle as a TIMA reload → IF[2]=1.
- Read FF03 and FF10 → 8'hff. Store 8'h00 to IF, then read IF → 8'he0.
